// File: rtl/contador_pkg.sv
// Shared constants for the cascaded modulo counter: default digit width,
// seconds / MM:SS modulus packings and direction encoding.
package contador_pkg;

    localparam int DW_DEF = 4;

    // Digit 0 sits in the low field.
    localparam logic [7:0]  MOD_SEG  = {4'd6, 4'd10};
    localparam logic [15:0] MOD_MMSS = {4'd10, 4'd10, 4'd6, 4'd10};

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

    // A modulus of 2^DW does not fit in its DW-bit field, so it is packed as 0.
    function automatic int mod_value(input int field, input int dw);
        return (field == 0) ? (1 << dw) : field;
    endfunction

endpackage

// File: rtl/contador_mod_n_digito.sv
// One modulo-M digit: clear, saturating parallel load, up/down step,
// and flags for terminal value and zero.
module contador_mod_n_digito
    import contador_pkg::*;
#(
    parameter int M  = 10,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] d,
    input  logic          en_in,
    input  logic          up,
    output logic [DW-1:0] q,
    output logic          term,
    output logic          zero_d
);

    localparam logic [DW-1:0] TOP   = DW'(M - 1);
    localparam logic [DW:0]   MOD_W = (DW + 1)'(M);

    logic [DW-1:0] nxt;
    logic [DW-1:0] ld_val;

    always_comb begin
        // Out-of-range load fields clamp so the digit never leaves 0..M-1.
        ld_val = ({1'b0, d} >= MOD_W) ? TOP : d;
        if (up == UP) nxt = (q == TOP) ? '0 : q + 1'b1;
        else          nxt = (q == '0)  ? TOP : q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clear)      q <= '0;
        else if (load)  q <= ld_val;
        else if (en_in) q <= nxt;
    end

    assign term   = (up == UP) ? (q == TOP) : (q == '0);
    assign zero_d = (q == '0);

endmodule

// File: rtl/contador_mod_n_cascata.sv
// Cascaded multi-digit modulo counter with per-digit moduli, parallel load,
// up/down count, chain terminal count and zero flag.
// Build option CONTADOR_SATURA_EN: hold at the terminal value instead of wrapping.
module contador_mod_n_cascata
    import contador_pkg::*;
#(
    parameter int                    DIGITS = 2,
    parameter int                    DW     = DW_DEF,
    parameter logic [DW*DIGITS-1:0]  MODS   = MOD_SEG
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 loadn,
    input  logic                 en,
    input  logic                 up,
    input  logic [DW*DIGITS-1:0] data,
    output logic [DW*DIGITS-1:0] digits,
    output logic                 tc,
    output logic                 zero
);

    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] zero_d;
    logic [DIGITS:0]   chain;
    logic              all_term;
    logic              hold;

    assign all_term = &term;

`ifdef CONTADOR_SATURA_EN
    assign hold = all_term;
`else
    assign hold = 1'b0;
`endif

    // Every stepping digit updates on the same edge; the chain is pure combinational gating.
    assign chain[0] = en & ~hold;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        localparam int M = mod_value(int'(MODS[DW*i +: DW]), DW);

        contador_mod_n_digito #(
            .M  (M),
            .DW (DW)
        ) u_dig (
            .clk    (clk),
            .clear  (clear),
            .load   (~loadn),
            .d      (data[DW*i +: DW]),
            .en_in  (chain[i]),
            .up     (up),
            .q      (digits[DW*i +: DW]),
            .term   (term[i]),
            .zero_d (zero_d[i])
        );

        assign chain[i+1] = chain[i] & term[i];
    end

    assign tc   = en & all_term;
    assign zero = &zero_d;

endmodule

// File: tb/tb_contador_mod_n_cascata.sv
// Vector-table bench for the cascaded counter: a mod6/mod10 seconds chain
// and a 4-digit MM:SS chain, checked through an expected-result queue.
module tb_contador_mod_n_cascata;
    import contador_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_clear, a_loadn, a_en, a_up;
    logic [7:0]  a_data, a_digits;
    logic        a_tc, a_zero;
    logic        b_clear, b_loadn, b_en, b_up;
    logic [15:0] b_data, b_digits;
    logic        b_tc, b_zero;

    contador_mod_n_cascata #(.DIGITS(2), .DW(4), .MODS(MOD_SEG)) dut_a (
        .clk(clk), .clear(a_clear), .loadn(a_loadn), .en(a_en), .up(a_up),
        .data(a_data), .digits(a_digits), .tc(a_tc), .zero(a_zero)
    );

    contador_mod_n_cascata #(.DIGITS(4), .DW(4), .MODS(MOD_MMSS)) dut_b (
        .clk(clk), .clear(b_clear), .loadn(b_loadn), .en(b_en), .up(b_up),
        .data(b_data), .digits(b_digits), .tc(b_tc), .zero(b_zero)
    );

    typedef struct {
        logic        sel;   // 0: seconds chain, 1: MM:SS chain
        logic        clr, ldn, en, up;
        logic [15:0] data;
        logic [15:0] q;
        logic        tc, z;
    } vec_t;

    typedef struct {
        logic        sel;
        logic [15:0] q;
        logic        tc, z;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

`ifdef CONTADOR_SATURA_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic v(input logic sel, input logic clr, input logic ldn, input logic en,
                     input logic up, input logic [15:0] data, input logic [15:0] q,
                     input logic tc, input logic z);
        vec_t r;
        r.sel = sel; r.clr = clr; r.ldn = ldn; r.en = en; r.up = up;
        r.data = data; r.q = q; r.tc = tc; r.z = z;
        tbl.push_back(r);
    endtask

    function automatic logic [15:0] bcd(input int n);
        return {8'h00, 4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic idle_inputs();
        a_clear = 0; a_loadn = 1; a_en = 0; a_up = 0; a_data = '0;
        b_clear = 0; b_loadn = 1; b_en = 0; b_up = 0; b_data = '0;
    endtask

    task automatic drive(input vec_t r);
        idle_inputs();
        if (!r.sel) begin
            a_clear = r.clr; a_loadn = r.ldn; a_en = r.en; a_up = r.up; a_data = r.data[7:0];
        end else begin
            b_clear = r.clr; b_loadn = r.ldn; b_en = r.en; b_up = r.up; b_data = r.data;
        end
    endtask

    task automatic check(input string name);
        exp_t        e;
        logic [15:0] q;
        logic        tc, z;
        e  = sb.pop_front();
        q  = e.sel ? b_digits : {8'h00, a_digits};
        tc = e.sel ? b_tc : a_tc;
        z  = e.sel ? b_zero : a_zero;
        tests++;
        if (q !== e.q || tc !== e.tc || z !== e.z) begin
            fails++;
            $display("FAIL %s: got digits=%h tc=%b zero=%b, expected digits=%h tc=%b zero=%b",
                     name, q, tc, z, e.q, e.tc, e.z);
        end
    endtask

    initial begin
        exp_t e;
        idle_inputs();

        // Seconds chain (mod6 tens, mod10 units).
        v(0, 1,1,0,0, 16'h00, 16'h00, 0, 1);          // clear
        v(0, 0,0,0,0, 16'h59, 16'h59, 0, 0);          // load 59
        for (int k = 58; k >= 49; k--)
            v(0, 0,1,1,0, 16'h00, bcd(k), 0, 0);      // count down 58..49
        v(0, 0,0,0,0, 16'h01, 16'h01, 0, 0);
        v(0, 0,1,1,0, 16'h00, 16'h00, 1, 1);          // reach 00, tc while en
        if (SAT) v(0, 0,1,1,0, 16'h00, 16'h00, 1, 1); // held at terminal
        else     v(0, 0,1,1,0, 16'h00, 16'h59, 0, 0); // wrap to 59
        v(0, 0,0,1,1, 16'h7C, 16'h59, 1, 0);          // saturating load, up terminal
        v(0, 0,0,1,0, 16'h6A, 16'h59, 0, 0);
        v(0, 0,0,0,0, 16'h58, 16'h58, 0, 0);
        v(0, 0,1,1,1, 16'h00, 16'h59, 1, 0);
        if (SAT) begin
            v(0, 0,1,1,1, 16'h00, 16'h59, 1, 0);
            for (int k = 0; k < 3; k++) v(0, 0,1,0,1, 16'h00, 16'h59, 0, 0);
        end else begin
            v(0, 0,1,1,1, 16'h00, 16'h00, 0, 1);
            for (int k = 0; k < 3; k++) v(0, 0,1,0,1, 16'h00, 16'h00, 0, 1);
        end
        v(0, 0,0,0,0, 16'h37, 16'h37, 0, 0);
        v(0, 1,0,1,1, 16'h55, 16'h00, 0, 1);          // clear beats load and count
        v(0, 0,0,0,0, 16'h22, 16'h22, 0, 0);
        v(0, 0,1,1,1, 16'h00, 16'h23, 0, 0);
        v(0, 0,1,1,1, 16'h00, 16'h24, 0, 0);
        v(0, 1,1,1,1, 16'h00, 16'h00, 0, 1);          // clear mid-count
        v(0, 0,0,0,0, 16'h10, 16'h10, 0, 0);
        v(0, 0,1,1,0, 16'h00, 16'h09, 0, 0);          // borrow ripples into tens
        v(0, 0,1,1,1, 16'h00, 16'h10, 0, 0);          // direction change

        // MM:SS chain.
        v(1, 1,1,0,0, 16'h0000, 16'h0000, 0, 1);
        v(1, 0,0,0,0, 16'h1000, 16'h1000, 0, 0);
        v(1, 0,1,1,0, 16'h0000, 16'h0959, 0, 0);      // 10:00 -> 09:59 in one edge
        v(1, 0,0,0,0, 16'h0001, 16'h0001, 0, 0);
        v(1, 0,1,1,0, 16'h0000, 16'h0000, 1, 1);
        if (SAT) v(1, 0,1,1,0, 16'h0000, 16'h0000, 1, 1);
        else     v(1, 0,1,1,0, 16'h0000, 16'h9959, 0, 0);
        v(1, 0,0,1,1, 16'hFFFF, 16'h9959, 1, 0);      // every field clamps

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            e.sel = tbl[i].sel; e.q = tbl[i].q; e.tc = tbl[i].tc; e.z = tbl[i].z;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i));
        end

        // tc follows en and up combinationally, without any clock edge.
        @(negedge clk);
        idle_inputs();
        a_loadn = 0; a_data = 8'h00;
        @(posedge clk); #1;
        a_loadn = 1; a_en = 1; a_up = 0;
        #1;
        e.sel = 0; e.q = 16'h00; e.tc = 1; e.z = 1; sb.push_back(e);
        check("tc_comb_down");
        a_up = 1;
        #1;
        e.sel = 0; e.q = 16'h00; e.tc = 0; e.z = 1; sb.push_back(e);
        check("tc_comb_up");
        a_en = 0;
        @(negedge clk);

        // Load without en and with up ignored: 3-cycle hold then one step.
        a_loadn = 0; a_data = 8'h45; a_up = 1;
        @(posedge clk); #1;
        a_loadn = 1;
        repeat (3) @(posedge clk);
        #1;
        e.sel = 0; e.q = 16'h45; e.tc = 0; e.z = 0; sb.push_back(e);
        check("hold_after_load");
        @(negedge clk);
        a_en = 1; a_up = 0;
        @(posedge clk); #1;
        e.sel = 0; e.q = 16'h44; e.tc = 0; e.z = 0; sb.push_back(e);
        check("step_after_hold");

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
